// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the single-issue RV32I core: owns pc/ir, steps
// FETCH-DECODE-EXECUTE-MEM-WB, qualifies write strobes and halts on faults.
module core_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic        dec_wEn,
  input  logic        dec_mem_wEn,
  input  logic        dec_wb_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        busy,
  output logic        retired,
  output logic [31:0] instret,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t      state, state_next;
  logic [15:0] wait_cnt;
  logic [1:0]  code_next;
  logic        retire;
  logic        legal;

  always_comb begin
    legal = ir[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011};
  end

  always_comb begin
    state_next = state;
    code_next  = fault_code;
    retire     = 1'b0;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH: begin
        if (imem_ack) begin
          state_next = DECODE;
        end else if (wait_cnt == TIMEOUT) begin
          state_next = HALT;
          code_next  = 2'd2;
        end
      end
      DECODE: begin
        if (legal) begin
          state_next = EXECUTE;
        end else begin
          state_next = HALT;
          code_next  = 2'd1;
        end
      end
      EXECUTE: state_next = (dec_wb_sel || dec_mem_wEn) ? MEM : WB;
      MEM: begin
        // Stores retire in the ack cycle itself; loads still need WB.
        if (dmem_ack) begin
          if (dec_mem_wEn) begin
            retire     = 1'b1;
            state_next = stop ? IDLE : FETCH;
          end else begin
            state_next = WB;
          end
        end else if (wait_cnt == TIMEOUT) begin
          state_next = HALT;
          code_next  = 2'd3;
        end
      end
      WB: begin
        retire     = 1'b1;
        state_next = stop ? IDLE : FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Requests and strobes decode from state (plus decoder fields), never from an ack.
  always_comb begin
    imem_req  = (state == FETCH);
    imem_addr = pc;
    dmem_req  = (state == MEM);
    dmem_we   = (state == MEM) && dec_mem_wEn;
    rf_we     = (state == WB) && dec_wEn;
    busy      = (state != IDLE) && (state != HALT);
    fault     = (state == HALT);
    retired   = retire;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      instret    <= '0;
      fault_code <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_next;
      fault_code <= code_next;
      if (state == FETCH && imem_ack) ir <= imem_rdata;
      if (retire) begin
        pc      <= pc + 32'd4;
        instret <= instret + 32'd1;
      end
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if ((state == FETCH && !imem_ack) || (state == MEM && !dmem_ack)) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

endmodule
